hawk_seek_initiator: RTL

- Controller-side seek engine for the Hawk disk interface; it drives the drive's cylinder-strobe, cylinder-address and RTZ inputs, and consumes addr_ack, on_cyl, seek_err and adint.
- It accepts a seek command from controller logic and range-checks the cylinder locally. It then runs the strobe/ack handshake, waits for on-cylinder, and recovers from seek errors with RTZ plus retry.
- It reports completion and a status code to the controller sequencer.

---
 rtl/hawk_seek_initiator_if.sv | 20 ++
 rtl/hawk_seek_initiator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hawk_seek_initiator_if.sv
// Drive-side bus between the Hawk seek initiator (master) and the disk drive (slave).
interface hawk_seek_initiator_if;
    logic [8:0] cylad;
    logic       cyl_strobe;
    logic       rtzs;
    logic       addr_ack;
    logic       on_cyl;
    logic       seek_err;
    logic       adint;

    modport master (
        output cylad, cyl_strobe, rtzs,
        input  addr_ack, on_cyl, seek_err, adint
    );

    modport slave (
        input  cylad, cyl_strobe, rtzs,
        output addr_ack, on_cyl, seek_err, adint
    );
endinterface

// File: rtl/hawk_seek_initiator.sv
// Hawk disk seek engine: range check, strobe/ack handshake, on-cylinder wait,
// and RTZ-based retry after seek errors.
module hawk_seek_initiator #(
    parameter int unsigned MAX_CYL       = 405,
    parameter int unsigned SETUP_CYCLES  = 4,
    parameter int unsigned STROBE_CYCLES = 8,
    parameter int unsigned ACK_TIMEOUT   = 256,
    parameter int unsigned SEEK_TIMEOUT  = 1000000,
    parameter int unsigned RTZ_CYCLES    = 8,
    parameter int unsigned RETRIES       = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cmd_valid,
    input  logic [8:0]                   cmd_cyl,
    input  logic                         cmd_rtz,
    output logic                         busy,
    output logic                         done,
    output logic [2:0]                   status,
    output logic [8:0]                   cur_cyl,
    hawk_seek_initiator_if.master        drv
);

    localparam int unsigned CntW   = 20;
    localparam int unsigned RetryW = $clog2(RETRIES + 2);

    localparam logic [CntW-1:0]   SetupLast  = CntW'(SETUP_CYCLES - 1);
    localparam logic [CntW-1:0]   StrobeLast = CntW'(STROBE_CYCLES - 1);
    localparam logic [CntW-1:0]   AckLast    = CntW'(ACK_TIMEOUT - 1);
    localparam logic [CntW-1:0]   SeekLast   = CntW'(SEEK_TIMEOUT - 1);
    localparam logic [CntW-1:0]   RtzLast    = CntW'(RTZ_CYCLES - 1);
    localparam logic [8:0]        MaxCyl     = 9'(MAX_CYL);
    localparam logic [RetryW-1:0] RetryMax   = RetryW'(RETRIES);

    localparam logic [2:0] StatOk      = 3'd0;
    localparam logic [2:0] StatBadAddr = 3'd1;
    localparam logic [2:0] StatAckTo   = 3'd2;
    localparam logic [2:0] StatSeekErr = 3'd3;
    localparam logic [2:0] StatSeekTo  = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StWaitAck,
        StWaitOnCyl,
        StRtzPulse,
        StRtzWait,
        StFinish
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [2:0]          status_q, status_d;
    logic [8:0]          cur_cyl_q, cur_cyl_d;
    logic [8:0]          cylad_q, cylad_d;
    logic [RetryW-1:0]   retry_q, retry_d;
    logic                rtz_cmd_q, rtz_cmd_d;

    // Drive inputs are asynchronous to clk; only the second-stage copies are used.
    logic [3:0] sync1_q, sync2_q;
    logic       ack_s, on_s, err_s, adint_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {drv.adint, drv.seek_err, drv.on_cyl, drv.addr_ack};
            sync2_q <= sync1_q;
        end
    end

    assign ack_s   = sync2_q[0];
    assign on_s    = sync2_q[1];
    assign err_s   = sync2_q[2];
    assign adint_s = sync2_q[3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            status_q  <= StatOk;
            cur_cyl_q <= '0;
            cylad_q   <= '0;
            retry_q   <= '0;
            rtz_cmd_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            status_q  <= status_d;
            cur_cyl_q <= cur_cyl_d;
            cylad_q   <= cylad_d;
            retry_q   <= retry_d;
            rtz_cmd_q <= rtz_cmd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        cur_cyl_d = cur_cyl_q;
        cylad_d   = cylad_q;
        retry_d   = retry_q;
        rtz_cmd_d = rtz_cmd_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    status_d  = StatOk;
                    rtz_cmd_d = cmd_rtz;
                    if (cmd_rtz) begin
                        state_d = StRtzPulse;
                    end else if (cmd_cyl > MaxCyl) begin
                        status_d = StatBadAddr;
                        state_d  = StFinish;
                    end else begin
                        cylad_d = cmd_cyl;
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                if (cnt_q >= SetupLast) state_d = StStrobe;
            end
            StStrobe: begin
                if (cnt_q >= StrobeLast) state_d = StWaitAck;
            end
            StWaitAck: begin
                if (adint_s) begin
                    status_d = StatBadAddr;
                    state_d  = StFinish;
                end else if (ack_s) begin
                    state_d = StWaitOnCyl;
                end else if (cnt_q >= AckLast) begin
                    status_d = StatAckTo;
                    state_d  = StFinish;
                end
            end
            StWaitOnCyl: begin
                // seek_err wins over a coincident on_cyl
                if (err_s) begin
                    if (retry_q < RetryMax) begin
                        state_d = StRtzPulse;
                    end else begin
                        status_d = StatSeekErr;
                        state_d  = StFinish;
                    end
                end else if (on_s) begin
                    cur_cyl_d = cylad_q;
                    status_d  = StatOk;
                    state_d   = StFinish;
                end else if (cnt_q >= SeekLast) begin
                    status_d = StatSeekTo;
                    state_d  = StFinish;
                end
            end
            StRtzPulse: begin
                if (cnt_q >= RtzLast) state_d = StRtzWait;
            end
            StRtzWait: begin
                if (err_s) begin
                    status_d = StatSeekErr;
                    state_d  = StFinish;
                end else if (on_s) begin
                    cur_cyl_d = '0;
                    if (rtz_cmd_q) begin
                        status_d = StatOk;
                        state_d  = StFinish;
                    end else begin
                        retry_d = retry_q + RetryW'(1);
                        state_d = StSetup;
                    end
                end else if (cnt_q >= SeekLast) begin
                    status_d = StatSeekTo;
                    state_d  = StFinish;
                end
            end
            StFinish: begin
                retry_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // The ack timeout runs from the strobe rise, so STROBE->WAIT_ACK keeps counting.
        if ((state_d != state_q) && (state_q != StStrobe)) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        drv.cyl_strobe = 1'b0;
        drv.rtzs       = 1'b0;
        unique case (state_q)
            StIdle: ;
            StStrobe: begin
                busy           = 1'b1;
                drv.cyl_strobe = 1'b1;
            end
            StRtzPulse: begin
                busy     = 1'b1;
                drv.rtzs = 1'b1;
            end
            StFinish: done = 1'b1;
            default:  busy = 1'b1;
        endcase
    end

    assign status    = status_q;
    assign cur_cyl   = cur_cyl_q;
    assign drv.cylad = cylad_q;

endmodule
